// File: rtl/queue_drain_serializer_pkg.sv
// Shared types and sizing helpers for queue_drain_serializer.
// Optional build macro: QUEUE_DRAIN_SERIALIZER_TIMEOUT_EN.
package queue_drain_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    WAIT    = 2'd2,
    SEND    = 2'd3
  } state_e;

  function automatic int num_beats(
    input int data_size,
    input int beat_width
  );
    return (data_size + beat_width - 1) / beat_width;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_NUM_BEATS = num_beats(678, 128);
  localparam int DEF_IDX_W     = idx_width(DEF_NUM_BEATS);

endpackage

// File: rtl/queue_drain_serializer_beat_slicer.sv
// Capture register and beat index; slices the packet into
// zero-padded beats.
module beat_slicer
  import queue_drain_serializer_pkg::*;
#(
  parameter int DATA_SIZE  = 678,
  parameter int BEAT_WIDTH = 128
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic [DATA_SIZE-1:0]  i_packet,
  input  logic                  i_advance,
  output logic [BEAT_WIDTH-1:0] o_data,
  output logic                  o_last
);

  localparam int NUM_BEATS = num_beats(DATA_SIZE, BEAT_WIDTH);
  localparam int IDX_W     = idx_width(NUM_BEATS);
  localparam int PAD_W     = NUM_BEATS * BEAT_WIDTH;

  logic [BEAT_WIDTH-1:0] r_beat [NUM_BEATS];
  logic [IDX_W-1:0]      r_idx;
  logic [PAD_W-1:0]      w_padded;
  logic                  w_last;

  // Zero-extension supplies the padding of the final beat.
  assign w_padded = PAD_W'(i_packet);
  assign w_last   = (r_idx == IDX_W'(NUM_BEATS - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < NUM_BEATS; b++) begin
        r_beat[b] <= '0;
      end
      r_idx <= '0;
    end else if (i_load) begin
      for (int b = 0; b < NUM_BEATS; b++) begin
        r_beat[b] <= w_padded[b*BEAT_WIDTH +: BEAT_WIDTH];
      end
      r_idx <= '0;
    end else if (i_advance) begin
      r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
    end
  end

  assign o_data = r_beat[r_idx];
  assign o_last = w_last;

endmodule

// File: rtl/queue_drain_serializer.sv
// Scheduler-side drain of the per-core queues into a beat stream.
// Optional: QUEUE_DRAIN_SERIALIZER_TIMEOUT_EN adds a WAIT watchdog.
module queue_drain_serializer
  import queue_drain_serializer_pkg::*;
#(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int DATA_SIZE        = 678,
  parameter int BEAT_WIDTH       = 128,
  parameter int REGISTER_SIZE    = 32
`ifdef QUEUE_DRAIN_SERIALIZER_TIMEOUT_EN
  ,parameter int TIMEOUT_CYCLES  = 16
`endif
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                sched_valid,
  input  logic [$clog2(NUMBER_OF_QUEUES)-1:0] sched_id,
  output logic                                sched_ready,
  input  logic [NUMBER_OF_QUEUES-1:0]         empty,
  output logic                                scheduler_to_queues_ready,
  output logic [$clog2(NUMBER_OF_QUEUES)-1:0] core_id,
  input  logic                                queues_to_serializer_valid,
  input  logic [DATA_SIZE-1:0]                queues_to_serializer_packet,
  output logic [BEAT_WIDTH-1:0]               beat_data,
  output logic                                beat_valid,
  output logic                                beat_last,
  input  logic                                beat_ready,
`ifdef QUEUE_DRAIN_SERIALIZER_TIMEOUT_EN
  output logic                                timeout_error,
`endif
  output logic                                busy,
  output logic [REGISTER_SIZE-1:0]            dropped_count
);

  localparam int CID_W = $clog2(NUMBER_OF_QUEUES);

  state_e                   r_state;
  logic [CID_W-1:0]         r_core_id;
  logic [REGISTER_SIZE-1:0] r_dropped;
  logic                     w_idle;
  logic                     w_send;
  logic                     w_load;
  logic                     w_advance;
  logic [BEAT_WIDTH-1:0]    w_data;
  logic                     w_last;

  assign w_idle    = (r_state == IDLE);
  assign w_send    = (r_state == SEND);
  assign w_load    = (r_state == WAIT) & queues_to_serializer_valid;
  assign w_advance = w_send & beat_ready;

`ifdef QUEUE_DRAIN_SERIALIZER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_wait_cnt;
  logic            r_timeout;
  logic            w_expire;

  assign w_expire = (r_state == WAIT) & ~queues_to_serializer_valid
                  & (r_wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (r_state == WAIT) begin
        r_wait_cnt <= r_wait_cnt + TO_W'(1);
      end else begin
        r_wait_cnt <= '0;
      end
      if (w_expire) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign timeout_error = r_timeout;
`else
  logic w_expire;
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_core_id <= '0;
      r_dropped <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (sched_valid) begin
            // Decisions for an empty queue are counted, never issued.
            if (empty[sched_id]) begin
              if (r_dropped != '1) begin
                r_dropped <= r_dropped + REGISTER_SIZE'(1);
              end
            end else begin
              r_core_id <= sched_id;
              r_state   <= REQUEST;
            end
          end
        end
        REQUEST: r_state <= WAIT;
        WAIT: begin
          if (queues_to_serializer_valid) begin
            r_state <= SEND;
          end else if (w_expire) begin
            r_state <= IDLE;
          end
        end
        SEND: begin
          if (beat_ready && w_last) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  beat_slicer #(
    .DATA_SIZE  (DATA_SIZE),
    .BEAT_WIDTH (BEAT_WIDTH)
  ) u_slicer (
    .clock     (clock),
    .reset     (reset),
    .i_load    (w_load),
    .i_packet  (queues_to_serializer_packet),
    .i_advance (w_advance),
    .o_data    (w_data),
    .o_last    (w_last)
  );

  assign sched_ready               = w_idle & ~reset;
  assign scheduler_to_queues_ready = (r_state == REQUEST);
  assign core_id                   = r_core_id;
  assign beat_valid                = w_send;
  assign beat_data                 = w_send ? w_data : '0;
  assign beat_last                 = w_send & w_last;
  assign busy                      = ~w_idle;
  assign dropped_count             = r_dropped;

endmodule

// File: tb/tb_queue_drain_serializer.sv
// Scoreboard bench for queue_drain_serializer.
// Build with QUEUE_DRAIN_SERIALIZER_TIMEOUT_EN to cover the watchdog.
module tb_queue_drain_serializer;

  localparam int NQ  = 4;
  localparam int DW  = 678;
  localparam int BW  = 128;
  localparam int RS  = 32;
  localparam int NB  = (DW + BW - 1) / BW;
  localparam int CW  = $clog2(NQ);

  typedef struct {
    logic [BW-1:0] data;
    logic          last;
    logic [CW-1:0] cid;
  } beat_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          sched_valid;
  logic [CW-1:0] sched_id;
  logic          sched_ready;
  logic [NQ-1:0] empty;
  logic          stqr;
  logic [CW-1:0] core_id;
  logic          qv;
  logic [DW-1:0] qpkt;
  logic [BW-1:0] beat_data;
  logic          beat_valid;
  logic          beat_last;
  logic          beat_ready;
  logic          busy;
  logic [RS-1:0] dropped_count;
`ifdef QUEUE_DRAIN_SERIALIZER_TIMEOUT_EN
  logic          timeout_error;
`endif

  int    checks = 0;
  int    errors = 0;
  int    hs     = 0;
  int    hi     = 0;
  int    rises  = 0;
  bit    prev_r = 1'b0;
  beat_t exp_q[$];

  always #5 clock = ~clock;

  queue_drain_serializer dut (
    .clock                       (clock),
    .reset                       (reset),
    .sched_valid                 (sched_valid),
    .sched_id                    (sched_id),
    .sched_ready                 (sched_ready),
    .empty                       (empty),
    .scheduler_to_queues_ready   (stqr),
    .core_id                     (core_id),
    .queues_to_serializer_valid  (qv),
    .queues_to_serializer_packet (qpkt),
    .beat_data                   (beat_data),
    .beat_valid                  (beat_valid),
    .beat_last                   (beat_last),
    .beat_ready                  (beat_ready),
`ifdef QUEUE_DRAIN_SERIALIZER_TIMEOUT_EN
    .timeout_error               (timeout_error),
`endif
    .busy                        (busy),
    .dropped_count               (dropped_count)
  );

  task automatic check(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] make_pkt(input logic [7:0] tag);
    logic [NB*BW-1:0] t;
    for (int i = 0; i < NB * BW / 32; i++) begin
      t[i*32 +: 32] = $urandom;
    end
    t[7:0]    = 8'hA5;
    t[15:8]   = tag;
    t[DW-1]   = 1'b1;
    return t[DW-1:0];
  endfunction

  // Request-pulse observer and beat scoreboard.
  always @(negedge clock) begin
    if (stqr) hi++;
    if (stqr && !prev_r) rises++;
    prev_r = stqr;
    if (!reset && beat_valid) begin
      if (exp_q.size() == 0) begin
        check("beat_unexp", 1, 0);
      end else begin
        check("beat_data", beat_data, exp_q[0].data);
        check("beat_last", beat_last, exp_q[0].last);
        check("beat_cid", core_id, exp_q[0].cid);
        if (beat_ready) begin
          void'(exp_q.pop_front());
          hs++;
        end
      end
    end
  end

  task automatic decide(input logic [CW-1:0] id);
    @(posedge clock); #1;
    sched_valid = 1'b1;
    sched_id    = id;
    @(negedge clock);
    check("sched_rdy", sched_ready, 1);
    @(posedge clock); #1;
    sched_valid = 1'b0;
  endtask

  task automatic serve(
    input logic [DW-1:0] pkt,
    input logic [CW-1:0] cid
  );
    beat_t         e;
    logic [DW-1:0] sh;
    @(negedge clock);
    check("req_lat", stqr, 1);
    check("req_cid", core_id, cid);
    @(posedge clock); #1;
    for (int b = 0; b < NB; b++) begin
      sh     = pkt >> (b * BW);
      e.data = sh[BW-1:0];
      e.last = (b == NB - 1);
      e.cid  = cid;
      exp_q.push_back(e);
    end
    qv   = 1'b1;
    qpkt = pkt;
    @(posedge clock); #1;
    qv   = 1'b0;
    @(negedge clock);
    check("beat_lat", beat_valid, 1);
  endtask

  task automatic wait_idle(input bit stall);
    int n = 0;
    forever begin
      @(posedge clock); #1;
      beat_ready = stall ? (n % 3 == 0) : 1'b1;
      n++;
      @(negedge clock); #1;
      if (!busy) break;
      if (n > 200) begin
        check("idle_tmo", 0, 1);
        break;
      end
    end
    beat_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got hang want finish");
    $fatal(1);
  end

  initial begin
    int r0;
    int h0;
    int n;
    reset       = 1'b1;
    sched_valid = 1'b0;
    sched_id    = '0;
    empty       = '0;
    qv          = 1'b0;
    qpkt        = '0;
    beat_ready  = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_bv", beat_valid, 0);
    check("rst_req", stqr, 0);
    check("rst_drop", dropped_count, 0);
    check("rst_srdy", sched_ready, 0);
    check("rst_data", beat_data, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("idle_srdy", sched_ready, 1);

    // Plain packet, full-rate downstream.
    hs = 0; r0 = rises; h0 = hi;
    decide(2);
    serve(make_pkt(8'h01), 2);
    wait_idle(0);
    check("t1_beats", hs, NB);
    check("t1_rises", rises - r0, 1);
    check("t1_hicyc", hi - h0, 1);
    check("t1_qempty", exp_q.size(), 0);

    // Decision to an empty queue is dropped.
    empty = 4'b0010; h0 = hi;
    decide(1);
    @(negedge clock);
    check("t2_drop", dropped_count, 1);
    check("t2_req", stqr, 0);
    check("t2_srdy", sched_ready, 1);
    check("t2_busy", busy, 0);
    check("t2_hicyc", hi - h0, 0);
    empty = '0;

    // Downstream back-pressure.
    hs = 0;
    decide(1);
    serve(make_pkt(8'h02), 1);
    wait_idle(1);
    check("t3_beats", hs, NB);
    check("t3_busy", busy, 0);

    // Back-to-back packets.
    r0 = rises; h0 = hi; hs = 0;
    decide(0);
    serve(make_pkt(8'h03), 0);
    wait_idle(0);
    decide(3);
    serve(make_pkt(8'h04), 3);
    wait_idle(0);
    check("t4_rises", rises - r0, 2);
    check("t4_hicyc", hi - h0, 2);
    check("t4_beats", hs, 2 * NB);

    // Asynchronous reset during beat 2.
    hs = 0;
    decide(2);
    serve(make_pkt(8'h05), 2);
    n = 0;
    while (hs < 2 && n < 50) begin
      @(negedge clock); #1;
      n++;
    end
    check("t5_reach", hs >= 2, 1);
    @(posedge clock); #3;
    reset = 1'b1;
    #1;
    check("t5_bv", beat_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_data", beat_data, 0);
    check("t5_drop", dropped_count, 0);
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    h0 = hs; n = 0;
    repeat (10) begin
      @(negedge clock);
      if (beat_valid) n++;
    end
    check("t5_nobeat", n, 0);
    check("t5_nohs", hs - h0, 0);

`ifdef QUEUE_DRAIN_SERIALIZER_TIMEOUT_EN
    // No packet arrives after the request.
    decide(1);
    check("t6_err0", timeout_error, 0);
    repeat (16) @(posedge clock);
    #1;
    check("t6_still", busy, 1);
    @(posedge clock); #1;
    check("t6_idle", busy, 0);
    check("t6_err", timeout_error, 1);
    check("t6_srdy", sched_ready, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
